// File: rtl/axon_spike_scheduler.sv
// rtl/axon_spike_scheduler.sv - walks one timestep's spiking axons and fetches their synapse rows
//
// Acts as Wishbone master to synapse_matrix. For every set bit of the spike
// vector (lowest index first) it reads the 256-bit connection row and hands
// {axon index, row} to the neuron update stage over a valid/ready handshake.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   start_i, axon_spikes_i    timestep start pulse and spike vector
//   busy_o, done_o, err_o     status: busy, done pulse, sticky ack timeout
//   row_count_o               rows delivered in the current/last timestep
//   m_cyc_o .. m_adr_o        Wishbone master request (read only)
//   m_ack_i, conn_i           Wishbone ack and synapse row data
//   row_valid_o, row_ready_i  output row handshake
//   row_axon_o, row_data_o    output row payload
module axon_spike_scheduler #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NUM_AXONS = 256,
  parameter int          ROW_BYTES = 32,
  parameter int          TIMEOUT   = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic [NUM_AXONS-1:0] axon_spikes_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [8:0]           row_count_o,
  output logic                 m_cyc_o,
  output logic                 m_stb_o,
  output logic                 m_we_o,
  output logic [3:0]           m_sel_o,
  output logic [31:0]          m_adr_o,
  input  logic                 m_ack_i,
  input  logic [255:0]         conn_i,
  output logic                 row_valid_o,
  input  logic                 row_ready_i,
  output logic [7:0]           row_axon_o,
  output logic [255:0]         row_data_o
);

  localparam int ROW_SHIFT = $clog2(ROW_BYTES);
  localparam int TO_W      = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SCAN = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]           state;
  logic [NUM_AXONS-1:0] pending;
  logic [7:0]           axon_q;
  logic [TO_W-1:0]      to_cnt;
  logic [7:0]           lowest_idx;

  // Read-only master with full-word lanes; strobe mirrors cycle.
  assign m_stb_o = m_cyc_o;
  assign m_we_o  = 1'b0;
  assign m_sel_o = 4'hF;

  // Priority encoder: scanning downwards lets the lowest set bit win.
  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_AXONS - 1; i >= 0; i--) begin
      if (pending[i]) lowest_idx = 8'(i);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      pending     <= '0;
      axon_q      <= '0;
      to_cnt      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      row_count_o <= '0;
      m_cyc_o     <= 1'b0;
      m_adr_o     <= '0;
      row_valid_o <= 1'b0;
      row_axon_o  <= '0;
      row_data_o  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            pending     <= axon_spikes_i;
            row_count_o <= '0;
            err_o       <= 1'b0;
            busy_o      <= 1'b1;
            state       <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (pending == '0) begin
            state <= S_DONE;
          end else begin
            axon_q  <= lowest_idx;
            m_adr_o <= BASE_ADDR + (32'(lowest_idx) << ROW_SHIFT);
            m_cyc_o <= 1'b1;
            to_cnt  <= '0;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (m_ack_i) begin
            row_data_o      <= conn_i;
            row_axon_o      <= axon_q;
            pending[axon_q] <= 1'b0;
            m_cyc_o         <= 1'b0;
            row_valid_o     <= 1'b1;
            state           <= S_OUT;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            // Slave never answered: abandon the whole timestep.
            m_cyc_o <= 1'b0;
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
            pending <= '0;
            state   <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_OUT: begin
          // Bus stays idle here and in SCAN, so synapse_matrix drops its
          // ack on a negedge before the next request can sample it.
          if (row_ready_i) begin
            row_valid_o <= 1'b0;
            row_count_o <= row_count_o + 9'd1;
            state       <= S_SCAN;
          end
        end
        S_DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axon_spike_scheduler.sv
// tb/tb_axon_spike_scheduler.sv - directed self-checking bench for axon_spike_scheduler
module tb_axon_spike_scheduler;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [255:0] axon_spikes_i = '0;
  logic         busy_o, done_o, err_o;
  logic [8:0]   row_count_o;
  logic         m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]   m_sel_o;
  logic [31:0]  m_adr_o;
  logic         m_ack_i = 1'b0;
  logic [255:0] conn_i;
  logic         row_valid_o;
  logic         row_ready_i = 1'b0;
  logic [7:0]   row_axon_o;
  logic [255:0] row_data_o;

  logic slave_en  = 1'b1;
  logic ack_force = 1'b0;
  logic conn_a5   = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  axon_spike_scheduler dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .start_i       (start_i),
    .axon_spikes_i (axon_spikes_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .row_count_o   (row_count_o),
    .m_cyc_o       (m_cyc_o),
    .m_stb_o       (m_stb_o),
    .m_we_o        (m_we_o),
    .m_sel_o       (m_sel_o),
    .m_adr_o       (m_adr_o),
    .m_ack_i       (m_ack_i),
    .conn_i        (conn_i),
    .row_valid_o   (row_valid_o),
    .row_ready_i   (row_ready_i),
    .row_axon_o    (row_axon_o),
    .row_data_o    (row_data_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Zero-wait synapse_matrix: acks on the negedge after a request appears,
  // and drops the ack on the following negedge.
  always @(negedge wb_clk_i)
    m_ack_i <= ack_force | (slave_en & m_cyc_o & m_stb_o & ~m_ack_i);

  assign conn_i = m_cyc_o ? (conn_a5 ? {32{8'hA5}} : {8{m_adr_o}}) : '0;

  function automatic logic [255:0] exp_row(input int a);
    logic [31:0] adr;
    adr = 32'h3000_0000 + 32'(a) * 32'd32;
    return {8{adr}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic start_ts(input logic [255:0] v);
    axon_spikes_i = v;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    logic [255:0] v;
    int exp_order[3];
    int n, gap, done_at, r;
    logic gap_ok, seen_hi, prev_cyc, hold_ok, seq_ok, done_seen;
    logic [31:0] last_adr;

    // Reset state
    step(); step();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_count", row_count_o, 0);
    chk("rst_cyc", m_cyc_o, 0);
    chk("rst_stb", m_stb_o, 0);
    chk("rst_we", m_we_o, 0);
    chk("rst_sel", m_sel_o, 4'hF);
    chk("rst_adr", m_adr_o, 0);
    chk("rst_valid", row_valid_o, 0);
    chk("rst_data", row_data_o, 0);
    wb_rst_i = 1'b0;
    step();

    // Single axon 3, ready held high before valid
    conn_a5 = 1'b1;
    row_ready_i = 1'b1;
    v = '0; v[3] = 1'b1;
    start_ts(v);
    chk("t1_busy", busy_o, 1);
    chk("t1_cyc_scan", m_cyc_o, 0);
    step();
    chk("t1_cyc", m_cyc_o, 1);
    chk("t1_stb", m_stb_o, 1);
    chk("t1_adr", m_adr_o, 32'h3000_0060);
    step();
    chk("t1_valid", row_valid_o, 1);
    chk("t1_axon", row_axon_o, 3);
    chk("t1_data", row_data_o, {32{8'hA5}});
    chk("t1_cyc_drop", m_cyc_o, 0);
    step();
    chk("t1_valid_drop", row_valid_o, 0);
    chk("t1_count", row_count_o, 1);
    step();
    chk("t1_done_early", done_o, 0);
    step();
    chk("t1_done", done_o, 1);
    chk("t1_busy_low", busy_o, 0);
    step();
    chk("t1_done_pulse", done_o, 0);
    conn_a5 = 1'b0;

    // Ack while idle is ignored
    ack_force = 1'b1;
    step(); step(); step();
    chk("idle_ack_busy", busy_o, 0);
    chk("idle_ack_valid", row_valid_o, 0);
    chk("idle_ack_count", row_count_o, 1);
    ack_force = 1'b0;
    step();

    // Multi-axon ordering {200,0,17}
    exp_order[0] = 0; exp_order[1] = 17; exp_order[2] = 200;
    v = '0; v[200] = 1'b1; v[0] = 1'b1; v[17] = 1'b1;
    start_ts(v);
    n = 0; gap = 0; done_at = 0;
    gap_ok = 1'b1; seen_hi = 1'b0; prev_cyc = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (row_valid_o) begin
        if (n < 3) begin
          chk("t2_axon", row_axon_o, exp_order[n]);
          chk("t2_data", row_data_o, exp_row(exp_order[n]));
          chk("t2_cycle", c, 2 + 3 * n);
        end
        n++;
      end
      if (done_o && done_at == 0) done_at = c;
      if (m_cyc_o && !prev_cyc) begin
        if (seen_hi && gap < 2) gap_ok = 1'b0;
        seen_hi = 1'b1;
        gap = 0;
      end else if (!m_cyc_o) begin
        gap++;
      end
      prev_cyc = m_cyc_o;
    end
    chk("t2_rows", n, 3);
    chk("t2_gap", gap_ok, 1);
    chk("t2_done_at", done_at, 11);
    chk("t2_count", row_count_o, 3);

    // Backpressure on axons {5,6}, ack forced high during OUT
    row_ready_i = 1'b0;
    v = '0; v[5] = 1'b1; v[6] = 1'b1;
    start_ts(v);
    step();
    chk("t3_adr0", m_adr_o, 32'h3000_00A0);
    step();
    chk("t3_valid", row_valid_o, 1);
    chk("t3_axon", row_axon_o, 5);
    chk("t3_data", row_data_o, exp_row(5));
    ack_force = 1'b1;
    hold_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (!row_valid_o || row_axon_o != 8'd5 || row_data_o != exp_row(5) || m_cyc_o)
        hold_ok = 1'b0;
    end
    chk("t3_hold", hold_ok, 1);
    chk("t3_hold_count", row_count_o, 0);
    ack_force = 1'b0;
    row_ready_i = 1'b1;
    step();
    chk("t3_valid_drop", row_valid_o, 0);
    chk("t3_count1", row_count_o, 1);
    chk("t3_no_req_scan", m_cyc_o, 0);
    step();
    chk("t3_adr1", m_adr_o, 32'h3000_00C0);
    step();
    chk("t3_axon1", row_axon_o, 6);
    chk("t3_data1", row_data_o, exp_row(6));
    step();
    chk("t3_count2", row_count_o, 2);
    step(); step();
    chk("t3_done", done_o, 1);
    step();

    // All-zero spikes
    start_ts('0);
    chk("t4_busy", busy_o, 1);
    step();
    chk("t4_cyc", m_cyc_o, 0);
    chk("t4_done_early", done_o, 0);
    step();
    chk("t4_done", done_o, 1);
    chk("t4_count", row_count_o, 0);
    chk("t4_busy_low", busy_o, 0);
    step();

    // All-ones spikes
    start_ts('1);
    r = 0; seq_ok = 1'b1; done_seen = 1'b0; last_adr = '0;
    for (int c = 0; c < 900 && !done_seen; c++) begin
      step();
      if (m_cyc_o) last_adr = m_adr_o;
      if (row_valid_o) begin
        if (row_axon_o != r[7:0] || row_data_o != exp_row(r)) seq_ok = 1'b0;
        r++;
      end
      if (done_o) done_seen = 1'b1;
    end
    chk("t5_done_seen", done_seen, 1);
    chk("t5_rows", r, 256);
    chk("t5_seq", seq_ok, 1);
    chk("t5_last_adr", last_adr, 32'h3000_1FE0);
    chk("t5_count", row_count_o, 256);
    step();

    // Ack timeout
    slave_en = 1'b0;
    v = '0; v[9] = 1'b1;
    start_ts(v);
    for (int c = 1; c <= 16; c++) step();
    chk("t6_cyc_before", m_cyc_o, 1);
    step();
    chk("t6_cyc_after", m_cyc_o, 0);
    chk("t6_stb_after", m_stb_o, 0);
    chk("t6_err", err_o, 1);
    chk("t6_busy", busy_o, 0);
    done_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (done_o) done_seen = 1'b1;
    end
    chk("t6_no_done", done_seen, 0);
    chk("t6_err_sticky", err_o, 1);
    slave_en = 1'b1;
    v = '0; v[1] = 1'b1;
    start_ts(v);
    chk("t6_err_clear", err_o, 0);
    chk("t6_busy_again", busy_o, 1);
    step(); step(); step(); step(); step();
    chk("t6_done2", done_o, 1);
    chk("t6_axon2", row_axon_o, 1);
    step();

    // Async reset while in REQ
    v = '0; v[4] = 1'b1;
    start_ts(v);
    step();
    chk("t7_cyc_req", m_cyc_o, 1);
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk("t7_cyc_rst", m_cyc_o, 0);
    chk("t7_stb_rst", m_stb_o, 0);
    chk("t7_valid_rst", row_valid_o, 0);
    chk("t7_busy_rst", busy_o, 0);
    start_i = 1'b1;
    step();
    chk("t7_start_in_rst", busy_o, 0);
    start_i = 1'b0;
    wb_rst_i = 1'b0;
    step();
    chk("t7_no_row", row_valid_o, 0);
    chk("t7_idle", busy_o, 0);
    v = '0; v[2] = 1'b1;
    start_ts(v);
    chk("t7_accept", busy_o, 1);
    step();
    chk("t7_adr", m_adr_o, 32'h3000_0040);
    step();
    chk("t7_axon", row_axon_o, 2);
    step(); step(); step();
    chk("t7_done", done_o, 1);
    chk("t7_count", row_count_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
